// File: rtl/sram_arbiter_if.sv
// Bus bundle between the three SRAM requesters (video, CPU, loader), the
// arbiter and the external SRAM pins.
interface sram_arbiter_if;
  logic        rom_initialised;
  logic        vid_req;
  logic        cpu_req;
  logic        ldr_req;
  logic [20:0] vid_addr;
  logic [20:0] cpu_addr;
  logic [20:0] ldr_addr;
  logic        cpu_we;
  logic        ldr_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  ldr_wdata;
  logic        vid_ack;
  logic        cpu_ack;
  logic        ldr_ack;
  logic [7:0]  rdata;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_oe;
  logic        sram_we_n;
  logic [7:0]  sram_din;

  modport master (
    output rom_initialised,
    output vid_req, cpu_req, ldr_req,
    output vid_addr, cpu_addr, ldr_addr,
    output cpu_we, ldr_we,
    output cpu_wdata, ldr_wdata,
    output sram_din,
    input  vid_ack, cpu_ack, ldr_ack,
    input  rdata,
    input  sram_addr, sram_dout, sram_oe, sram_we_n
  );

  modport slave (
    input  rom_initialised,
    input  vid_req, cpu_req, ldr_req,
    input  vid_addr, cpu_addr, ldr_addr,
    input  cpu_we, ldr_we,
    input  cpu_wdata, ldr_wdata,
    input  sram_din,
    output vid_ack, cpu_ack, ldr_ack,
    output rdata,
    output sram_addr, sram_dout, sram_oe, sram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-port fixed-priority SRAM arbiter (video > CPU > loader), all outputs registered.
// Optional loader promotion over the CPU after repeated losses: define SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int ACC_CYC      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  // state  | meaning
  // IDLE   | arbitrate among eligible requests, latch the winner
  // SETUP  | address driven, write strobe held inactive
  // ACCESS | ACC_CYC cycles of strobe/data phase
  // TURN   | bus released, one-cycle ack to the granted port

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;
  typedef enum logic [1:0] {P_VID, P_CPU, P_LDR, P_NONE} port_t;

  state_t      state_q, state_d;
  port_t       gnt_q, gnt_d, win;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;
  logic [2:0]  ack_q, ack_d;
  logic        elig_vid, elig_cpu, elig_ldr;
  logic        promote;

  assign elig_vid = bus.rom_initialised & bus.vid_req;
  assign elig_cpu = bus.rom_initialised & bus.cpu_req;
  assign elig_ldr = bus.ldr_req;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;
  assign promote = (starve_q == 4'(STARVE_LIMIT));
`else
  assign promote = 1'b0;
`endif

  // Promotion lets the loader jump the CPU only; video always keeps top priority.
  always_comb begin
    win = P_NONE;
    if (elig_vid)
      win = P_VID;
    else if (elig_ldr && promote)
      win = P_LDR;
    else if (elig_cpu)
      win = P_CPU;
    else if (elig_ldr)
      win = P_LDR;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    oe_d    = 1'b0;
    we_n_d  = 1'b1;
    ack_d   = 3'b000;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    starve_d = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (win != P_NONE) begin
          state_d = SETUP;
          gnt_d   = win;
          case (win)
            P_VID: begin
              addr_d = bus.vid_addr;
              we_d   = 1'b0;
            end
            P_CPU: begin
              addr_d = bus.cpu_addr;
              we_d   = bus.cpu_we;
              dout_d = bus.cpu_wdata;
            end
            default: begin
              addr_d = bus.ldr_addr;
              we_d   = bus.ldr_we;
              dout_d = bus.ldr_wdata;
            end
          endcase
          oe_d = we_d;
        end
`ifdef SRAM_ARB_STARVE_GUARD_EN
        if (win == P_LDR)
          starve_d = 4'd0;
        else if (win == P_CPU && elig_ldr)
          starve_d = starve_q + 4'd1;
`endif
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(ACC_CYC - 1);
        we_n_d  = ~we_q;
        oe_d    = we_q;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = TURN;
          case (gnt_q)
            P_VID:   ack_d = 3'b001;
            P_CPU:   ack_d = 3'b010;
            P_LDR:   ack_d = 3'b100;
            default: ack_d = 3'b000;
          endcase
          if (!we_q)
            rdata_d = bus.sram_din;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = ~we_q;
          oe_d   = we_q;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= P_NONE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 21'd0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      ack_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
    end
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  always_ff @(posedge clk) begin
    if (reset)
      starve_q <= 4'd0;
    else
      starve_q <= starve_d;
  end
`endif

  assign bus.vid_ack   = ack_q[0];
  assign bus.cpu_ack   = ack_q[1];
  assign bus.ldr_ack   = ack_q[2];
  assign bus.rdata     = rdata_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_dout = dout_q;
  assign bus.sram_oe   = oe_q;
  assign bus.sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_sram_arbiter;
  localparam int ACC   = 2;
  localparam int ACC1  = 1;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();
  sram_arbiter_if bus1 ();

  sram_arbiter #(.ACC_CYC(ACC), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sram_arbiter #(.ACC_CYC(ACC1), .STARVE_LIMIT(LIMIT)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  assign bus1.sram_din = bus1.sram_addr[7:0] ^ 8'h5A;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  int          free_at;
  bit          cur_v;
  int          cur_t, cur_p;
  logic [20:0] cur_addr;
  bit          cur_we;
  logic [7:0]  cur_wdata, cur_rd;
  logic [20:0] exp_addr;
  logic [7:0]  exp_rdata;
  int          starve;
  logic [7:0]  ref_mem  [logic [20:0]];
  logic [7:0]  sram_mem [logic [20:0]];

  bit   sticky [3];
  bit   rand_mode;
  int   first_ack [3];
  int   ack_count [3];
  int   wen_low;
  logic [7:0] wen_dout;
  bit   wen_oe_bad;
  int   cpu_at_ldr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] sram_rd(input logic [20:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
  endfunction

  function automatic logic [20:0] p_addr(input int p);
    case (p)
      0:       return bus.vid_addr;
      1:       return bus.cpu_addr;
      default: return bus.ldr_addr;
    endcase
  endfunction

  function automatic bit p_we(input int p);
    case (p)
      0:       return 1'b0;
      1:       return bus.cpu_we;
      default: return bus.ldr_we;
    endcase
  endfunction

  function automatic logic [7:0] p_wdata(input int p);
    case (p)
      0:       return 8'h00;
      1:       return bus.cpu_wdata;
      default: return bus.ldr_wdata;
    endcase
  endfunction

  function automatic bit p_req(input int p);
    case (p)
      0:       return bus.vid_req;
      1:       return bus.cpu_req;
      default: return bus.ldr_req;
    endcase
  endfunction

  function automatic bit p_ack(input int p);
    case (p)
      0:       return bus.vid_ack;
      1:       return bus.cpu_ack;
      default: return bus.ldr_ack;
    endcase
  endfunction

  task automatic set_port(input int p, input logic r, input logic [20:0] a,
                          input logic w, input logic [7:0] d);
    case (p)
      0: begin bus.vid_req = r; bus.vid_addr = a; end
      1: begin bus.cpu_req = r; bus.cpu_addr = a; bus.cpu_we = w; bus.cpu_wdata = d; end
      default: begin bus.ldr_req = r; bus.ldr_addr = a; bus.ldr_we = w; bus.ldr_wdata = d; end
    endcase
  endtask

  task automatic drop_port(input int p);
    case (p)
      0:       bus.vid_req = 1'b0;
      1:       bus.cpu_req = 1'b0;
      default: bus.ldr_req = 1'b0;
    endcase
  endtask

  task automatic clear_obs();
    for (int p = 0; p < 3; p++) begin
      first_ack[p] = -1;
      ack_count[p] = 0;
    end
    wen_low    = 0;
    wen_dout   = 8'h00;
    wen_oe_bad = 1'b0;
    cpu_at_ldr = -1;
  endtask

  // One arbitration opportunity per free cycle; a grant occupies ACC+3 cycles.
  task automatic model_decide();
    int win;
    bit ev, ec, el, promo;
    if (cyc < free_at) return;
    ev    = bus.rom_initialised && bus.vid_req;
    ec    = bus.rom_initialised && bus.cpu_req;
    el    = bus.ldr_req;
    promo = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    promo = (starve == LIMIT);
`endif
    win = -1;
    if (ev)              win = 0;
    else if (el && promo) win = 2;
    else if (ec)         win = 1;
    else if (el)         win = 2;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    if (win == 2)             starve = 0;
    else if (win == 1 && el)  starve++;
`endif
    if (win >= 0) begin
      cur_v     = 1'b1;
      cur_t     = cyc;
      cur_p     = win;
      cur_addr  = p_addr(win);
      cur_we    = p_we(win);
      cur_wdata = p_wdata(win);
      if (cur_we) ref_mem[cur_addr] = cur_wdata;
      else        cur_rd = ref_rd(cur_addr);
      free_at = cyc + ACC + 3;
    end
  endtask

  task automatic check_cycle();
    bit setup, acc, turn;
    setup = cur_v && (cyc == cur_t + 1);
    acc   = cur_v && (cyc >= cur_t + 2) && (cyc <= cur_t + 1 + ACC);
    turn  = cur_v && (cyc == cur_t + 2 + ACC);
    if (setup) exp_addr = cur_addr;
    if (turn && !cur_we) exp_rdata = cur_rd;
    check("vid_ack", bus.vid_ack, turn && cur_p == 0);
    check("cpu_ack", bus.cpu_ack, turn && cur_p == 1);
    check("ldr_ack", bus.ldr_ack, turn && cur_p == 2);
    check("sram_we_n", bus.sram_we_n, !(acc && cur_we));
    check("sram_oe", bus.sram_oe, (setup || acc) && cur_we);
    check("sram_addr", bus.sram_addr, exp_addr);
    check("rdata", bus.rdata, exp_rdata);
    if (acc && cur_we) check("sram_dout", bus.sram_dout, cur_wdata);
    if (!bus.sram_we_n) begin
      wen_low++;
      wen_dout = bus.sram_dout;
      if (!bus.sram_oe) wen_oe_bad = 1'b1;
    end
    for (int p = 0; p < 3; p++) begin
      if (p_ack(p)) begin
        if (p == 2 && first_ack[2] < 0) cpu_at_ldr = ack_count[1];
        if (first_ack[p] < 0) first_ack[p] = cyc;
        ack_count[p]++;
      end
    end
  endtask

  task automatic step();
    model_decide();
    @(negedge clk);
    cyc++;
    check_cycle();
    if (!bus.sram_we_n) sram_mem[bus.sram_addr] = bus.sram_dout;
    bus.sram_din = sram_rd(bus.sram_addr);
    for (int p = 0; p < 3; p++)
      if (p_ack(p) && !sticky[p]) drop_port(p);
    if (rand_mode) begin
      if ($urandom_range(0, 19) == 0) bus.rom_initialised = ~bus.rom_initialised;
      for (int p = 0; p < 3; p++)
        if (!p_req(p) && $urandom_range(0, 3) == 0)
          set_port(p, 1'b1, 21'($urandom_range(0, 15)),
                   (p == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  task automatic do_reset();
    for (int p = 0; p < 3; p++) begin
      drop_port(p);
      sticky[p] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    cyc++;
    check("rst_acks", {bus.vid_ack, bus.cpu_ack, bus.ldr_ack}, 3'b000);
    check("rst_we_n", bus.sram_we_n, 1'b1);
    check("rst_oe", bus.sram_oe, 1'b0);
    check("rst_addr", bus.sram_addr, 21'd0);
    check("rst_dout", bus.sram_dout, 8'd0);
    check("rst_rdata", bus.rdata, 8'd0);
    reset     = 1'b0;
    cur_v     = 1'b0;
    free_at   = cyc;
    exp_addr  = 21'd0;
    exp_rdata = 8'd0;
    starve    = 0;
    bus.sram_din = sram_rd(bus.sram_addr);
  endtask

  initial begin
    int t0, a1, a2;
    reset = 1'b1;
    bus.rom_initialised = 1'b1;
    bus.sram_din = 8'h00;
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 21'd0, 1'b0, 8'h00);
    bus1.rom_initialised = 1'b1;
    bus1.vid_req = 1'b0; bus1.cpu_req = 1'b0; bus1.ldr_req = 1'b0;
    bus1.vid_addr = 21'd0; bus1.cpu_addr = 21'd0; bus1.ldr_addr = 21'd0;
    bus1.cpu_we = 1'b0; bus1.ldr_we = 1'b0;
    bus1.cpu_wdata = 8'h00; bus1.ldr_wdata = 8'h00;
    rand_mode = 1'b0;
    clear_obs();
    do_reset();

    // single CPU read
    ref_mem[21'h012345]  = 8'hA5;
    sram_mem[21'h012345] = 8'hA5;
    clear_obs();
    set_port(1, 1'b1, 21'h012345, 1'b0, 8'h00);
    t0 = cyc;
    for (int i = 0; i < 20 && first_ack[1] < 0; i++) step();
    check("cpu_read_latency", first_ack[1] - t0, 4);
    check("cpu_read_rdata", bus.rdata, 8'hA5);
    check("cpu_read_no_wen", wen_low, 0);
    repeat (3) step();

    // boot phase: only the loader is served
    bus.rom_initialised = 1'b0;
    clear_obs();
    set_port(0, 1'b1, 21'h000100, 1'b0, 8'h00);
    set_port(1, 1'b1, 21'h000200, 1'b0, 8'h00);
    set_port(2, 1'b1, 21'h05C000, 1'b1, 8'h3C);
    for (int i = 0; i < 20 && first_ack[2] < 0; i++) step();
    check("boot_ldr_first", (first_ack[2] >= 0) && first_ack[0] < 0 && first_ack[1] < 0, 1);
    check("boot_wen_cycles", wen_low, 2);
    check("boot_wen_dout", wen_dout, 8'h3C);
    check("boot_wen_oe", wen_oe_bad, 1'b0);
    repeat (10) step();
    check("boot_vid_cpu_wait", ack_count[0] + ack_count[1], 0);
    drop_port(0);
    drop_port(1);
    bus.rom_initialised = 1'b1;
    repeat (8) step();
    check("dropped_not_served", ack_count[0] + ack_count[1], 0);

    // simultaneous requests
    clear_obs();
    set_port(0, 1'b1, 21'h000011, 1'b0, 8'h00);
    set_port(1, 1'b1, 21'h05C000, 1'b0, 8'h00);
    set_port(2, 1'b1, 21'h000013, 1'b0, 8'h00);
    t0 = cyc;
    for (int i = 0; i < 40 && first_ack[2] < 0; i++) step();
    check("simul_vid_latency", first_ack[0] - t0, 4);
    check("simul_cpu_spacing", first_ack[1] - first_ack[0], 5);
    check("simul_ldr_spacing", first_ack[2] - first_ack[1], 5);
    repeat (3) step();

    // CPU held permanently against a waiting loader
    do_reset();
    clear_obs();
    sticky[1] = 1'b1;
    set_port(1, 1'b1, 21'h000020, 1'b0, 8'h00);
    set_port(2, 1'b1, 21'h000021, 1'b0, 8'h00);
    t0 = cyc;
    repeat (40) step();
`ifdef SRAM_ARB_STARVE_GUARD_EN
    check("starve_cpu_before_ldr", cpu_at_ldr, 4);
    check("starve_ldr_latency", first_ack[2] - t0, 24);
`else
    check("starve_ldr_never", ack_count[2], 0);
    check("starve_cpu_acks", ack_count[1], 8);
`endif

    // reset during the first ACCESS cycle of a write
    do_reset();
    clear_obs();
    set_port(2, 1'b1, 21'h000030, 1'b1, 8'hC3);
    step();
    step();
    check("abort_pre_wen", bus.sram_we_n, 1'b0);
    do_reset();
    clear_obs();
    repeat (8) step();
    check("abort_no_ack", ack_count[0] + ack_count[1] + ack_count[2], 0);
    set_port(1, 1'b1, 21'h000030, 1'b0, 8'h00);
    t0 = cyc;
    for (int i = 0; i < 20 && first_ack[1] < 0; i++) step();
    check("abort_idle_latency", first_ack[1] - t0, 4);
    repeat (3) step();

    // randomized traffic
    do_reset();
    clear_obs();
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    for (int p = 0; p < 3; p++) drop_port(p);
    repeat (12) step();
    check("random_traffic_served", (ack_count[0] > 0) && (ack_count[1] > 0) && (ack_count[2] > 0), 1);

    // ACC_CYC=1 instance: back-to-back video reads
    a1 = -1;
    a2 = -1;
    bus1.vid_addr = 21'h000033;
    bus1.vid_req  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus1.vid_ack) begin
        if (a1 < 0)      a1 = i;
        else if (a2 < 0) a2 = i;
      end
    end
    bus1.vid_req = 1'b0;
    check("acc1_latency", a1, 3);
    check("acc1_period", a2 - a1, 4);
    check("acc1_rdata", bus1.rdata, 8'h69);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
